cpu_control_unit: RTL and testbench
===================================

# cpu_control_unit

Multi-cycle control sequencer for the course CPU. It fetches each 8-bit instruction (opcode [7:4], immediate [3:0]) into an internal instruction register and steps it through fetch/decode/execute/memory/writeback states. It drives the program counter's IncPC/LoadPC/selPC/imm inputs plus the memory, ALU and register-file enables. It sits between instruction memory, the program counter and the datapath, and is the only source of those control strobes.

## Interface
Parameters:
- START_AUTO, 0: 1 = leave IDLE on the first clock after reset without waiting for `start`.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- CLB  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE when high.
- instr  in  8  memory read data; captured into IR at the end of FETCH.
- zero  in  1  ALU zero flag; sampled in EXEC.
- IncPC  out  1  PC increment enable.
- LoadPC  out  1  PC load enable.
- selPC  out  1  PC load source: 1 = register, 0 = imm.
- imm  out  4  IR[3:0].
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  accumulator/register write enable.
- aluOp  out  3  0 pass-B, 1 ADD, 2 SUB, 3 AND, 4 OR.
- selImm  out  1  ALU B operand is imm (LDI).
- halted  out  1  high in HALT.
- state  out  3  current state code (debug).

## Operation
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and, if it ever occurs, goes to IDLE.
- Outputs are Moore outputs decoded from the registered state and IR. Every output not listed for a state is 0.
- IDLE: goes to FETCH when start=1 or START_AUTO=1.
- FETCH: MemRead=1 and IncPC=1. IR<=instr. Next state DECODE.
- DECODE: no strobes. Next state EXEC.
- EXEC, by opcode:
  - 0 NOP: go to FETCH.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: aluOp per the table above, RegWrite=1, go to FETCH.
  - 5 LDI: aluOp=0, selImm=1, RegWrite=1, go to FETCH.
  - 6 LD: MemRead=1, go to MEM.
  - 7 ST: go to MEM.
  - 8 JMP: LoadPC=1, selPC=0, go to FETCH.
  - 9 JR: LoadPC=1, selPC=1, go to FETCH.
  - A JZ: LoadPC=1, selPC=0 only if zero=1, go to FETCH.
  - B JNZ: LoadPC=1, selPC=0 only if zero=0, go to FETCH.
  - F HLT: go to HALT.
  - C, D, E: executed as NOP.
- MEM:
  - LD: MemRead=1, go to WB.
  - ST: MemWrite=1, go to FETCH.
- WB (LD only): RegWrite=1, aluOp=0, go to FETCH.
- HALT: halted=1. Stays in HALT until CLB is asserted; `start` is ignored.
- IncPC and LoadPC are never both high. MemRead and MemWrite are never both high.

## Timing
- Reset (CLB=0, asynchronous): state=IDLE, IR=8'h00. All outputs are 0 immediately, without waiting for a clock edge. Reset has priority in every state; an instruction in progress is abandoned with no strobe issued afterwards.
- Cycles per instruction, FETCH to next FETCH:
  - NOP, ALU, LDI, JMP, JR, JZ, JNZ: 3.
  - ST: 4.
  - LD: 5.
- PC advances at the posedge ending FETCH. A jump takes effect at the posedge ending EXEC. The next FETCH therefore uses the target address with no wasted cycle.
- The conditional-jump decision uses `zero` as it stands during the EXEC cycle. The flag must be stable from the previous instruction.
- IR changes only at the posedge ending FETCH. imm is stable from DECODE until the next FETCH completes.
- From IDLE with start=1, the first FETCH occurs one cycle later. start is a level: lowering it after the CPU leaves IDLE has no effect.

## Test plan
- Reset and start: hold CLB=0 with start=1 → all outputs 0, state=0. Release CLB, keep start=0 for 3 cycles → stays IDLE. Raise start → state goes 0→1→2→3.
- ALU sequence: instr stream 8'h15 (ADD), 8'h00 (NOP) → IncPC pulses every 3 cycles; RegWrite=1 with aluOp=1 for exactly 1 cycle; no LoadPC.
- Jumps:
  - 8'h8A → LoadPC=1, selPC=0, imm=4'hA in EXEC.
  - 8'h90 → LoadPC=1, selPC=1.
  - 8'hA3 with zero=0 → no LoadPC; with zero=1 → LoadPC=1, imm=3.
  - 8'hB3 → the inverse of 8'hA3.
- Memory:
  - 8'h62 (LD) → MemRead in FETCH, EXEC and MEM; RegWrite in WB; 5-cycle period.
  - 8'h72 (ST) → MemWrite for exactly 1 cycle, in MEM; 4-cycle period.
- Halt and mid-operation reset: 8'hF0 → halted=1 and no further strobes for 10 cycles, even with start toggling. Pulse CLB low during the MEM cycle of an LD → outputs 0 at once, no RegWrite; after release the unit resumes in IDLE.
- Invariant checks, every cycle: IncPC and LoadPC never both 1; MemRead and MemWrite never both 1; state never 7.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer: captures each instruction into IR and walks it
// through FETCH/DECODE/EXEC/MEM/WB, driving PC, memory, ALU and register strobes.
module cpu_control_unit #(
    parameter bit START_AUTO = 1'b0
) (
    input  logic       clk,
    input  logic       CLB,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       zero,
    output logic       IncPC,
    output logic       LoadPC,
    output logic       selPC,
    output logic [3:0] imm,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [2:0] aluOp,
    output logic       selImm,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_LD  = 4'h6;
    localparam logic [3:0] OP_ST  = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JR  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;
    localparam logic [2:0] ALU_AND  = 3'd3;
    localparam logic [2:0] ALU_OR   = 3'd4;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_ir;
    logic [3:0] w_opcode;

    assign w_opcode = r_ir[7:4];
    assign imm      = r_ir[3:0];
    assign state    = r_state;

    // IR loads only on the edge that ends FETCH, so imm holds steady until then.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            r_state <= S_IDLE;
            r_ir    <= 8'h00;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FETCH) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_IDLE:   w_next_state = (start || START_AUTO) ? S_FETCH : S_IDLE;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_EXEC;
            S_EXEC: begin
                case (w_opcode)
                    OP_LD, OP_ST: w_next_state = S_MEM;
                    OP_HLT:       w_next_state = S_HALT;
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEM:    w_next_state = (w_opcode == OP_LD) ? S_WB : S_FETCH;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Moore decode of state and IR; only the conditional jumps look at zero.
    always_comb begin
        IncPC    = 1'b0;
        LoadPC   = 1'b0;
        selPC    = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        aluOp    = ALU_PASS;
        selImm   = 1'b0;
        halted   = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                IncPC   = 1'b1;
            end
            S_EXEC: begin
                case (w_opcode)
                    OP_ADD: begin
                        aluOp    = ALU_ADD;
                        RegWrite = 1'b1;
                    end
                    OP_SUB: begin
                        aluOp    = ALU_SUB;
                        RegWrite = 1'b1;
                    end
                    OP_AND: begin
                        aluOp    = ALU_AND;
                        RegWrite = 1'b1;
                    end
                    OP_OR: begin
                        aluOp    = ALU_OR;
                        RegWrite = 1'b1;
                    end
                    OP_LDI: begin
                        aluOp    = ALU_PASS;
                        selImm   = 1'b1;
                        RegWrite = 1'b1;
                    end
                    OP_LD:  MemRead = 1'b1;
                    OP_JMP: LoadPC  = 1'b1;
                    OP_JR: begin
                        LoadPC = 1'b1;
                        selPC  = 1'b1;
                    end
                    OP_JZ:  LoadPC = zero;
                    OP_JNZ: LoadPC = ~zero;
                    default: begin
                    end
                endcase
            end
            S_MEM: begin
                if (w_opcode == OP_LD) begin
                    MemRead = 1'b1;
                end else begin
                    MemWrite = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                aluOp    = ALU_PASS;
            end
            S_HALT:  halted = 1'b1;
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: drives instruction bytes cycle by cycle
// and compares every output against hand-computed per-state values.
module tb_cpu_control_unit;

  logic       clk;
  logic       CLB;
  logic       start;
  logic [7:0] instr;
  logic       zero;
  logic       IncPC;
  logic       LoadPC;
  logic       selPC;
  logic [3:0] imm;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic [2:0] aluOp;
  logic       selImm;
  logic       halted;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_control_unit #(.START_AUTO(1'b0)) dut (
    .clk      (clk),
    .CLB      (CLB),
    .start    (start),
    .instr    (instr),
    .zero     (zero),
    .IncPC    (IncPC),
    .LoadPC   (LoadPC),
    .selPC    (selPC),
    .imm      (imm),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .RegWrite (RegWrite),
    .aluOp    (aluOp),
    .selImm   (selImm),
    .halted   (halted),
    .state    (state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, IncPC, LoadPC, selPC, MemRead, MemWrite, RegWrite, aluOp, selImm, halted, imm}
  logic [17:0] obs;
  assign obs = {state, IncPC, LoadPC, selPC, MemRead, MemWrite, RegWrite,
                aluOp, selImm, halted, imm};

  function automatic logic [17:0] ex(input logic [2:0] st, input logic inc,
                                     input logic ld, input logic sel,
                                     input logic mr, input logic mw,
                                     input logic rw, input logic [2:0] op,
                                     input logic si, input logic h,
                                     input logic [3:0] im);
    return {st, inc, ld, sel, mr, mw, rw, op, si, h, im};
  endfunction

  task automatic chk_now(input string tag, input logic [17:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outputs=%05h expected=%05h", tag, obs, exp);
    end
    n_checks++;
    assert (!(IncPC && LoadPC)) else begin
      n_fail++;
      $error("FAIL %s_inc_load: IncPC=%b LoadPC=%b expected not both 1", tag, IncPC, LoadPC);
    end
    n_checks++;
    assert (!(MemRead && MemWrite)) else begin
      n_fail++;
      $error("FAIL %s_rd_wr: MemRead=%b MemWrite=%b expected not both 1", tag, MemRead, MemWrite);
    end
    n_checks++;
    assert (state !== 3'd7) else begin
      n_fail++;
      $error("FAIL %s_state7: state=%0d expected not 7", tag, state);
    end
  endtask

  task automatic chk(input string tag, input logic [17:0] exp);
    @(negedge clk);
    chk_now(tag, exp);
  endtask

  // Drives the byte for the coming FETCH, then checks FETCH and DECODE.
  task automatic fetch_decode(input string tag, input logic [7:0] ins,
                              input logic [3:0] prev_imm);
    instr = ins;
    chk({tag, "_fetch"},  ex(3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, prev_imm));
    chk({tag, "_decode"}, ex(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, ins[3:0]));
  endtask

  initial begin
    CLB   = 1'b0;
    start = 1'b1;
    instr = 8'h15;
    zero  = 1'b0;
    #1;
    chk_now("reset_async", 18'h0);
    chk("reset_hold", 18'h0);

    CLB   = 1'b1;
    start = 1'b0;
    chk("idle_0", 18'h0);
    chk("idle_1", 18'h0);
    chk("idle_2", 18'h0);
    start = 1'b1;

    // ADD then NOP; start dropped after leaving IDLE
    fetch_decode("add", 8'h15, 4'h0);
    start = 1'b0;
    chk("add_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 4'h5));
    fetch_decode("nop", 8'h00, 4'h5);
    chk("nop_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h0));

    fetch_decode("sub", 8'h2C, 4'h0);
    chk("sub_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd2, 0, 0, 4'hC));
    fetch_decode("and", 8'h31, 4'hC);
    chk("and_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd3, 0, 0, 4'h1));
    fetch_decode("or", 8'h4F, 4'h1);
    chk("or_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd4, 0, 0, 4'hF));
    fetch_decode("ldi", 8'h57, 4'hF);
    chk("ldi_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd0, 1, 0, 4'h7));
    fetch_decode("opc", 8'hC6, 4'h7);
    chk("opc_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h6));

    // jumps
    fetch_decode("jmp", 8'h8A, 4'h6);
    chk("jmp_exec", ex(3'd3, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 4'hA));
    fetch_decode("jr", 8'h90, 4'hA);
    chk("jr_exec", ex(3'd3, 0, 1, 1, 0, 0, 0, 3'd0, 0, 0, 4'h0));
    zero = 1'b0;
    fetch_decode("jz0", 8'hA3, 4'h0);
    chk("jz0_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h3));
    zero = 1'b1;
    fetch_decode("jz1", 8'hA3, 4'h3);
    chk("jz1_exec", ex(3'd3, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 4'h3));
    zero = 1'b0;
    fetch_decode("jnz0", 8'hB3, 4'h3);
    chk("jnz0_exec", ex(3'd3, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 4'h3));
    zero = 1'b1;
    fetch_decode("jnz1", 8'hB3, 4'h3);
    chk("jnz1_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h3));
    zero = 1'b0;

    // LD: 5 cycles, ST: 4 cycles
    fetch_decode("ld", 8'h62, 4'h3);
    chk("ld_exec", ex(3'd3, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 4'h2));
    chk("ld_mem",  ex(3'd4, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 4'h2));
    chk("ld_wb",   ex(3'd5, 0, 0, 0, 0, 0, 1, 3'd0, 0, 0, 4'h2));
    fetch_decode("st", 8'h72, 4'h2);
    chk("st_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h2));
    chk("st_mem",  ex(3'd4, 0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 4'h2));

    // HALT holds through start toggling
    fetch_decode("hlt", 8'hF0, 4'h2);
    chk("hlt_exec", ex(3'd3, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 4'h0));
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      chk("halt_hold", ex(3'd6, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 4'h0));
    end

    // reset out of HALT, then abort an LD in its MEM cycle
    CLB = 1'b0;
    #1;
    chk_now("halt_reset", 18'h0);
    @(negedge clk);
    CLB   = 1'b1;
    start = 1'b1;
    fetch_decode("ld2", 8'h62, 4'h0);
    start = 1'b0;
    chk("ld2_exec", ex(3'd3, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 4'h2));
    chk("ld2_mem",  ex(3'd4, 0, 0, 0, 1, 0, 0, 3'd0, 0, 0, 4'h2));
    CLB = 1'b0;
    #1;
    chk_now("mid_reset", 18'h0);
    chk("mid_reset_hold", 18'h0);
    CLB = 1'b1;
    chk("resume_idle_0", 18'h0);
    chk("resume_idle_1", 18'h0);
    start = 1'b1;
    fetch_decode("resume", 8'h15, 4'h0);
    chk("resume_exec", ex(3'd3, 0, 0, 0, 0, 0, 1, 3'd1, 0, 0, 4'h5));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
